// File: rtl/nn_accelerator.sv
// nn_accelerator: memory-mapped single-neuron fixed-point inference engine.
// The host loads N_IN weights, a bias and an N_IN-element input vector over the
// write port. Writing the last input element launches a job. The job runs a
// sequential MAC, adds the bias, then applies ReLU and saturation. Each result
// is appended to an on-chip result memory that is read back over the
// registered read port.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   write_enable  qualifies write_addr/write_data for one cycle
//   write_addr    memory-map write address
//   write_data    write data (low Q_SIZE bits used)
//   read_addr     memory-map read address, sampled every cycle
//   read_data     registered read data (one cycle after read_addr)
//   busy          high while a job is computing or pending
module nn_accelerator #(
    parameter int MM_DEPTH  = 17,
    parameter int MM_SIZE   = 16,
    parameter int Q_SIZE    = 16,
    parameter int Q_FRAC    = 10,
    parameter int N_IN      = 3,
    parameter int OUT_DEPTH = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write_enable,
    input  logic [MM_DEPTH-1:0] write_addr,
    input  logic [MM_SIZE-1:0]  write_data,
    input  logic [MM_DEPTH-1:0] read_addr,
    output logic [Q_SIZE-1:0]   read_data,
    output logic                busy
);

    localparam int ACC_W  = 2 * Q_SIZE + 4;
    localparam int PROD_W = 2 * Q_SIZE;
    localparam int PTR_W  = $clog2(OUT_DEPTH);
    localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam int CTRL_ADDR   = 'h4000;
    localparam int STATUS_ADDR = 'h4001;
    localparam int W_BASE      = 'h4002;
    localparam int BIAS_ADDR   = W_BASE + N_IN;
    localparam int X_BASE      = BIAS_ADDR + 1;
    localparam int X_LAST      = X_BASE + N_IN - 1;

    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (Q_SIZE - 1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_FINISH,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic signed [Q_SIZE-1:0] weights [N_IN];
    logic signed [Q_SIZE-1:0] bias;
    logic signed [Q_SIZE-1:0] x_buf   [N_IN];
    logic signed [Q_SIZE-1:0] job_x   [N_IN];
    logic signed [Q_SIZE-1:0] pend_x  [N_IN];
    logic signed [Q_SIZE-1:0] snap_x  [N_IN];

    logic                     pend_valid;
    logic [PTR_W-1:0]         ptr;
    logic                     overflow;
    logic [IDX_W-1:0]         mac_idx;
    logic signed [ACC_W-1:0]  acc;
    logic [Q_SIZE-1:0]        result_mem [OUT_DEPTH];

    logic [Q_SIZE-1:0]        wr_word;
    logic                     trigger;
    logic                     ctrl_clear;
    logic                     last_mac;
    logic                     start_trig;
    logic                     start_pend;
    logic                     pend_load;
    logic                     job_drop;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  y_sum;
    logic [Q_SIZE-1:0]        y_out;
    logic [Q_SIZE-1:0]        status_word;
    logic [Q_SIZE-1:0]        rd_next;

    function automatic logic addr_is(input logic [MM_DEPTH-1:0] a, input int target);
        return a == MM_DEPTH'(target);
    endfunction

    assign wr_word    = write_data[Q_SIZE-1:0];
    assign trigger    = write_enable && addr_is(write_addr, X_LAST);
    assign ctrl_clear = write_enable && addr_is(write_addr, CTRL_ADDR) && write_data[0];
    assign last_mac   = (mac_idx == IDX_W'(N_IN - 1));
    assign busy       = (state != S_IDLE);

    // A job snapshot is the input buffer with the element being written
    // right now substituted into the last slot.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            snap_x[i] = x_buf[i];
        end
        snap_x[N_IN-1] = wr_word;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Job sequencing. FINISH hands over to the pending job when one exists,
    // so back-to-back jobs keep busy high. DONE keeps busy high for the cycle
    // in which the new result first becomes readable.
    always_comb begin
        next_state = state;
        start_trig = 1'b0;
        start_pend = 1'b0;
        pend_load  = 1'b0;
        job_drop   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (trigger) begin
                    start_trig = 1'b1;
                    next_state = S_MAC;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_MAC: begin
                if (last_mac) begin
                    next_state = S_FINISH;
                end
                if (trigger) begin
                    if (!pend_valid) begin
                        pend_load = 1'b1;
                    end else begin
                        job_drop = 1'b1;
                    end
                end
            end
            S_FINISH: begin
                if (pend_valid) begin
                    start_pend = 1'b1;
                    next_state = S_MAC;
                    pend_load  = trigger;
                end else if (trigger) begin
                    start_trig = 1'b1;
                    next_state = S_MAC;
                end else begin
                    next_state = S_DONE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath. Weights and bias are read live, and inputs come from the job
    // snapshot. The shift is arithmetic, so it truncates toward minus infinity.
    always_comb begin
        product = PROD_W'(weights[mac_idx]) * PROD_W'(job_x[mac_idx]);
        y_sum   = (acc >>> Q_FRAC) + ACC_W'(bias);
        if (y_sum[ACC_W-1]) begin
            y_out = '0;
        end else if (y_sum > Y_MAX) begin
            y_out = Y_MAX[Q_SIZE-1:0];
        end else begin
            y_out = y_sum[Q_SIZE-1:0];
        end
    end

    // Read-side views: STATUS packing and the registered read mux.
    always_comb begin
        status_word             = '0;
        status_word[0]          = busy;
        status_word[1]          = overflow;
        status_word[8 +: PTR_W] = ptr;

        rd_next = '0;
        if (read_addr < MM_DEPTH'(OUT_DEPTH)) begin
            rd_next = result_mem[read_addr[PTR_W-1:0]];
        end else if (addr_is(read_addr, STATUS_ADDR)) begin
            rd_next = status_word;
        end else if (addr_is(read_addr, BIAS_ADDR)) begin
            rd_next = bias;
        end
        for (int i = 0; i < N_IN; i++) begin
            if (addr_is(read_addr, W_BASE + i)) begin
                rd_next = weights[i];
            end
            if (addr_is(read_addr, X_BASE + i)) begin
                rd_next = x_buf[i];
            end
        end
    end

    // Registers, job slots, pointer/overflow and read data. CTRL clear wins
    // over a same-cycle pointer increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) begin
                weights[i] <= '0;
                x_buf[i]   <= '0;
                job_x[i]   <= '0;
                pend_x[i]  <= '0;
            end
            bias       <= '0;
            pend_valid <= 1'b0;
            ptr        <= '0;
            overflow   <= 1'b0;
            mac_idx    <= '0;
            acc        <= '0;
            read_data  <= '0;
        end else begin
            read_data <= rd_next;

            if (write_enable) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (addr_is(write_addr, W_BASE + i)) begin
                        weights[i] <= wr_word;
                    end
                    if (addr_is(write_addr, X_BASE + i)) begin
                        x_buf[i] <= wr_word;
                    end
                end
                if (addr_is(write_addr, BIAS_ADDR)) begin
                    bias <= wr_word;
                end
            end

            if (start_trig) begin
                job_x   <= snap_x;
                acc     <= '0;
                mac_idx <= '0;
            end else if (start_pend) begin
                job_x   <= pend_x;
                acc     <= '0;
                mac_idx <= '0;
            end else if (state == S_MAC) begin
                acc <= acc + ACC_W'(product);
                if (!last_mac) begin
                    mac_idx <= mac_idx + 1'b1;
                end
            end

            if (pend_load) begin
                pend_x     <= snap_x;
                pend_valid <= 1'b1;
            end else if (start_pend) begin
                pend_valid <= 1'b0;
            end

            if (ctrl_clear) begin
                overflow <= 1'b0;
            end else if (job_drop) begin
                overflow <= 1'b1;
            end

            if (ctrl_clear) begin
                ptr <= '0;
            end else if (state == S_FINISH) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // Result memory has no reset. It is written only from FINISH, and reset
    // forces the FSM to IDLE, so an aborted job never writes a result.
    always_ff @(posedge clk) begin
        if (state == S_FINISH) begin
            result_mem[ptr] <= y_out;
        end
    end

endmodule

// File: tb/tb_nn_accelerator.sv
// tb_nn_accelerator: directed scoreboard bench for nn_accelerator.
// Stimulus pushes expected read values and expected busy run lengths into
// queues. Two monitors pop and compare them as the DUT produces read data or
// ends a busy period.
module tb_nn_accelerator;

    localparam logic [16:0] CTRL   = 17'h04000;
    localparam logic [16:0] STATUS = 17'h04001;
    localparam logic [16:0] W0     = 17'h04002;
    localparam logic [16:0] W1     = 17'h04003;
    localparam logic [16:0] W2     = 17'h04004;
    localparam logic [16:0] BIAS   = 17'h04005;
    localparam logic [16:0] X0     = 17'h04006;
    localparam logic [16:0] X1     = 17'h04007;
    localparam logic [16:0] X2     = 17'h04008;

    typedef struct {
        int    expVal;
        string name;
    } readExp_t;

    logic        clk;
    logic        reset;
    logic        writeEnable;
    logic [16:0] writeAddr;
    logic [15:0] writeData;
    logic [16:0] readAddr;
    logic [15:0] readData;
    logic        busy;

    logic        rdReq;
    logic        rdValidD;
    readExp_t    readQ[$];
    int          busyQ[$];
    int          runLen;
    int          assertCount;
    int          failCount;

    nn_accelerator dut (
        .clk         (clk),
        .reset       (reset),
        .write_enable(writeEnable),
        .write_addr  (writeAddr),
        .write_data  (writeData),
        .read_addr   (readAddr),
        .read_data   (readData),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Common comparison used by every monitor.
    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // One write cycle; write_enable stays high until the next call or idle.
    task automatic applyStimulus(input logic [16:0] addr, input logic [15:0] data);
        @(negedge clk);
        writeEnable = 1'b1;
        writeAddr   = addr;
        writeData   = data;
    endtask

    task automatic issueRead(input logic [16:0] addr, input int expVal, input string name);
        readExp_t e;
        @(negedge clk);
        writeEnable = 1'b0;
        readAddr    = addr;
        rdReq       = 1'b1;
        e.expVal    = expVal;
        e.name      = name;
        readQ.push_back(e);
        @(negedge clk);
        rdReq = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        @(negedge clk);
        writeEnable = 1'b0;
        while (busy && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL wait_idle: busy still 1 after %0d cycles, required 0", maxCycles);
        end
    endtask

    // Read data monitor: read_data one cycle after a requested read.
    always @(posedge clk) rdValidD <= rdReq;

    always @(negedge clk) begin
        if (rdValidD) begin
            if (readQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL read_unexpected: got 0x%h, required no read", readData);
            end else begin
                readExp_t e;
                e = readQ.pop_front();
                checkOutput(e.name, int'(readData), e.expVal);
            end
        end
    end

    // Busy monitor: measures each busy period and checks its length.
    always @(negedge clk) begin
        if (busy) begin
            runLen++;
        end else if (runLen != 0) begin
            if (busyQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL busy_unexpected: run of %0d cycles, required none", runLen);
            end else begin
                checkOutput("busy_run_length", runLen, busyQ.pop_front());
            end
            runLen = 0;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertCount = 0;
        failCount   = 0;
        runLen      = 0;
        rdReq       = 1'b0;
        reset       = 1'b0;
        writeEnable = 1'b0;
        writeAddr   = '0;
        writeData   = '0;
        readAddr    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b1;
        issueRead(STATUS, 16'h0000, "reset_status");
        issueRead(W0, 0, "reset_weight0");
        issueRead(BIAS, 0, "reset_bias");

        // Basic neuron: 0.5 weights, bias 2000
        applyStimulus(W0, 16'd512);
        applyStimulus(W1, 16'd512);
        applyStimulus(W2, 16'd512);
        applyStimulus(BIAS, 16'd2000);
        busyQ.push_back(5);
        applyStimulus(X0, 16'd120);
        applyStimulus(X1, 16'd200);
        applyStimulus(X2, 16'd512);
        waitIdle(50);
        issueRead(17'h00000, 2416, "basic_result");
        issueRead(STATUS, 16'h0100, "basic_status_ptr1");
        issueRead(W1, 512, "weight1_readback");
        issueRead(X1, 200, "x1_readback");
        issueRead(17'h04009, 0, "unmapped_read");
        issueRead(CTRL, 0, "ctrl_read_zero");

        // Writes to read-only locations are ignored
        applyStimulus(STATUS, 16'hFFFF);
        applyStimulus(17'h00000, 16'h1234);
        issueRead(STATUS, 16'h0100, "status_write_ignored");
        issueRead(17'h00000, 2416, "result_write_ignored");

        // Back-to-back vectors after a pointer clear
        applyStimulus(CTRL, 16'h0001);
        issueRead(STATUS, 0, "ctrl_clear_ptr");
        busyQ.push_back(13);
        applyStimulus(X0, 16'd120);
        applyStimulus(X1, 16'd200);
        applyStimulus(X2, 16'd512);
        applyStimulus(X0, 16'd1024);
        applyStimulus(X1, 16'd1024);
        applyStimulus(X2, 16'd1024);
        applyStimulus(X0, 16'd120);
        applyStimulus(X1, 16'd200);
        applyStimulus(X2, 16'd512);
        waitIdle(100);
        issueRead(17'h00000, 2416, "b2b_result0");
        issueRead(17'h00001, 3536, "b2b_result1");
        issueRead(17'h00002, 2416, "b2b_result2");
        issueRead(STATUS, 16'h0300, "b2b_status_no_ovf");

        // ReLU clamps a negative sum
        applyStimulus(BIAS, 16'hEC78);
        busyQ.push_back(5);
        applyStimulus(X0, 16'd120);
        applyStimulus(X1, 16'd200);
        applyStimulus(X2, 16'd512);
        waitIdle(50);
        issueRead(17'h00003, 0, "relu_result");

        // Saturation at the largest positive word
        applyStimulus(W0, 16'd32767);
        applyStimulus(W1, 16'd32767);
        applyStimulus(W2, 16'd32767);
        applyStimulus(BIAS, 16'd0);
        busyQ.push_back(5);
        applyStimulus(X0, 16'd32767);
        applyStimulus(X1, 16'd32767);
        applyStimulus(X2, 16'd32767);
        waitIdle(50);
        issueRead(17'h00004, 32767, "saturate_result");
        issueRead(STATUS, 16'h0500, "status_ptr5");

        // Overflow: four triggers on consecutive cycles; the first two jobs
        // run, while the third and fourth are dropped
        applyStimulus(W0, 16'd512);
        applyStimulus(W1, 16'd512);
        applyStimulus(W2, 16'd512);
        applyStimulus(BIAS, 16'd2000);
        applyStimulus(X0, 16'd120);
        applyStimulus(X1, 16'd200);
        busyQ.push_back(9);
        applyStimulus(X2, 16'd512);
        applyStimulus(X2, 16'd1024);
        applyStimulus(X2, 16'd0);
        applyStimulus(X2, 16'h7FFF);
        waitIdle(50);
        issueRead(17'h00005, 2416, "ovf_first_job");
        issueRead(17'h00006, 2672, "ovf_pending_job");
        issueRead(STATUS, 16'h0702, "ovf_status");
        applyStimulus(CTRL, 16'h0001);
        issueRead(STATUS, 16'h0000, "ovf_cleared");

        // Reset mid-job: busy drops at once and no result is written
        busyQ.push_back(2);
        applyStimulus(X2, 16'd512);
        @(negedge clk);
        writeEnable = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        issueRead(STATUS, 16'h0000, "midjob_reset_status");
        issueRead(W0, 0, "midjob_reset_weight");
        issueRead(X1, 0, "midjob_reset_xbuf");

        repeat (3) @(negedge clk);
        checkOutput("readq_drained", readQ.size(), 0);
        checkOutput("busyq_drained", busyQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
